// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
//   Receive side of the VGA timing interface. Recovers the pixel/line position
//   from incoming hsync/vsync, validates the frame geometry and declares lock
//   after LOCK_FRAMES consecutive clean frames.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous reset, active-low
//   i_pix_en       pixel-tick enable; all counting advances only on ticks
//   i_hsync        horizontal sync, asynchronous to i_clk
//   i_vsync        vertical sync, asynchronous to i_clk
//   o_h_pos[9:0]   column inside the active window, 0 elsewhere
//   o_v_pos[9:0]   row inside the active window, 0 elsewhere
//   o_active       locked and inside the active window
//   o_locked       timing validated
//   o_frame_start  one-clk pulse on each vsync leading edge while locked
//   o_err          one-clk pulse on any timing violation
//   o_err_cnt[7:0] saturating violation count
//
// Configuration
//   VGA_SYNC_ERRCNT_EN  when defined, o_err_cnt counts err pulses (saturating
//                       at 255, cleared only by reset); otherwise it is tied 0.
// ---------------------------------------------------------------------------
module vga_sync_decoder #(
    parameter int   H_TOTAL     = 800,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   H_ACTIVE    = 640,
    parameter int   V_TOTAL     = 525,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter int   V_ACTIVE    = 480,
    parameter int   LOCK_FRAMES = 2,
    parameter logic SYNC_POL    = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pix_en,
    input  logic       i_hsync,
    input  logic       i_vsync,
    output logic [9:0] o_h_pos,
    output logic [9:0] o_v_pos,
    output logic       o_active,
    output logic       o_locked,
    output logic       o_frame_start,
    output logic       o_err,
    output logic [7:0] o_err_cnt
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ST   = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END  = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_ST   = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END  = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [7:0] LK_N   = 8'(LOCK_FRAMES);
    localparam logic [9:0] C_MAX  = 10'd1023;
    localparam logic [9:0] C_PRE  = 10'd1022;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // ---------------- sync inputs: 2-flop synchronizer + edge register
    logic r_hs_s1, r_hs_s2, r_hs_d, r_hs_pend;
    logic r_vs_s1, r_vs_s2, r_vs_d, r_vs_pend;
    logic w_hs_raw, w_vs_raw, w_hs_edge, w_vs_edge;

    assign w_hs_raw = (r_hs_s2 == SYNC_POL) && (r_hs_d != SYNC_POL);
    assign w_vs_raw = (r_vs_s2 == SYNC_POL) && (r_vs_d != SYNC_POL);
    // An edge arriving on a non-tick clk is held pending until the next tick
    // so a slow pixel enable never loses it.
    assign w_hs_edge = i_pix_en && (w_hs_raw || r_hs_pend);
    assign w_vs_edge = i_pix_en && (w_vs_raw || r_vs_pend);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_hs_s1   <= ~SYNC_POL;
            r_hs_s2   <= ~SYNC_POL;
            r_hs_d    <= ~SYNC_POL;
            r_vs_s1   <= ~SYNC_POL;
            r_vs_s2   <= ~SYNC_POL;
            r_vs_d    <= ~SYNC_POL;
            r_hs_pend <= 1'b0;
            r_vs_pend <= 1'b0;
        end else begin
            r_hs_s1   <= i_hsync;
            r_hs_s2   <= r_hs_s1;
            r_hs_d    <= r_hs_s2;
            r_vs_s1   <= i_vsync;
            r_vs_s2   <= r_vs_s1;
            r_vs_d    <= r_vs_s2;
            r_hs_pend <= ~i_pix_en & (r_hs_pend | w_hs_raw);
            r_vs_pend <= ~i_pix_en & (r_vs_pend | w_vs_raw);
        end
    end

    // ---------------- counters, checks, FSM
    state_t     r_state;
    logic [9:0] r_hc, r_vc;
    logic [7:0] r_fc;
    logic       r_h_arm;   // a reference hsync edge has been seen since leaving SEARCH

    logic w_h_to, w_v_to, w_line_err, w_frame_err, w_err;
    logic w_chk, w_lk, w_win;

    assign w_chk = (r_state != SEARCH);
    assign w_lk  = (r_state == LOCKED);

    // Timeouts fire once, on the tick the counter would step onto 1023.
    assign w_h_to      = i_pix_en && !w_hs_edge && (r_hc == C_PRE);
    assign w_v_to      = w_hs_edge && !w_vs_edge && (r_vc == C_PRE);
    assign w_line_err  = w_chk && w_hs_edge && r_h_arm && (r_hc != H_LAST);
    assign w_frame_err = w_chk && w_vs_edge && (r_vc != V_LAST);
    assign w_err       = w_line_err || w_frame_err || w_h_to || w_v_to;

    assign w_win = (r_hc >= H_ST) && (r_hc < H_END) &&
                   (r_vc >= V_ST) && (r_vc < V_END);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= SEARCH;
            r_hc          <= 10'd0;
            r_vc          <= 10'd0;
            r_fc          <= 8'd0;
            r_h_arm       <= 1'b0;
            o_h_pos       <= 10'd0;
            o_v_pos       <= 10'd0;
            o_active      <= 1'b0;
            o_locked      <= 1'b0;
            o_frame_start <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            if (i_pix_en) begin
                if (w_hs_edge)
                    r_hc <= 10'd0;
                else if (r_hc != C_MAX)
                    r_hc <= r_hc + 10'd1;
                // A coincident vsync edge wins over the line increment.
                if (w_vs_edge)
                    r_vc <= 10'd0;
                else if (w_hs_edge && (r_vc != C_MAX))
                    r_vc <= r_vc + 10'd1;
            end

            case (r_state)
                SEARCH: begin
                    if (w_vs_edge && !w_err) begin
                        r_state <= CHECK;
                        r_fc    <= 8'd0;
                    end
                    // If hsync arrives with the leaving vsync edge, hc is
                    // already a valid reference for the next line check.
                    r_h_arm <= w_vs_edge && w_hs_edge && !w_err;
                end
                CHECK: begin
                    if (w_err) begin
                        r_state <= SEARCH;
                        r_h_arm <= 1'b0;
                    end else begin
                        r_h_arm <= r_h_arm | w_hs_edge;
                        if (w_vs_edge) begin
                            if (r_fc + 8'd1 >= LK_N)
                                r_state <= LOCKED;
                            r_fc <= r_fc + 8'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (w_err) begin
                        r_state <= SEARCH;
                        r_h_arm <= 1'b0;
                    end else begin
                        r_h_arm <= r_h_arm | w_hs_edge;
                    end
                end
                default: begin
                    r_state <= SEARCH;
                    r_h_arm <= 1'b0;
                end
            endcase

            // Status outputs follow the registered state, so locked/active
            // drop on the clk after the offending edge.
            o_locked      <= w_lk;
            o_active      <= w_lk && w_win;
            o_h_pos       <= (w_lk && w_win) ? (r_hc - H_ST) : 10'd0;
            o_v_pos       <= (w_lk && w_win) ? (r_vc - V_ST) : 10'd0;
            o_frame_start <= w_vs_edge && w_lk && !w_err;
            o_err         <= w_err;
        end
    end

`ifdef VGA_SYNC_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst)
            r_err_cnt <= 8'd0;
        else if (w_err && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign o_err_cnt = r_err_cnt;
`else
    assign o_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_decoder
//   Directed bench using a scaled-down timing (20 ticks x 12 lines) so whole
//   frames are short; the decoder logic is identical to the 640x480 build.
//   Active window: hc 5..16, vc 3..10. pix_en is high every 2nd clk.
// ---------------------------------------------------------------------------
module tb_vga_sync_decoder;

    localparam int HT = 20, HS = 3, HB = 2, HA = 12;
    localparam int VT = 12, VS = 1, VB = 2, VA = 8;
`ifdef VGA_SYNC_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, pix_en, hsync, vsync;
    logic [9:0] h_pos, v_pos;
    logic       active, locked, frame_start, err;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA),
        .LOCK_FRAMES(2), .SYNC_POL(1'b0)
    ) dut (
        .i_clk(clk), .i_rst(rst_n), .i_pix_en(pix_en),
        .i_hsync(hsync), .i_vsync(vsync),
        .o_h_pos(h_pos), .o_v_pos(v_pos), .o_active(active),
        .o_locked(locked), .o_frame_start(frame_start), .o_err(err),
        .o_err_cnt(err_cnt)
    );

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int err_n = 0, fs_n = 0, err_cyc = -1, fall_cyc = -1;
    logic prev_lk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (err) begin
            err_n   <= err_n + 1;
            err_cyc <= cyc;
        end
        if (frame_start) fs_n <= fs_n + 1;
        if (prev_lk && !locked) fall_cyc <= cyc;
        prev_lk <= locked;
    end

    typedef struct {
        int   line;
        int   px;
        logic act;
        int   h;
        int   v;
    } cp_t;
    cp_t cps[8];

    function automatic int exp_cnt(input int n);
        return CNT_EN ? ((n > 255) ? 255 : n) : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One pixel tick: inputs change, tick clk, idle clk.
    task automatic step(input logic hs, input logic vs);
        hsync  = hs;
        vsync  = vs;
        pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input int fid, input int short_line,
                             input int rst_line, input int rst_px,
                             input logic exp_lk, input logic do_cp);
        int len;
        for (int l = 0; l < VT; l++) begin
            len = (l == short_line) ? HT - 1 : HT;
            for (int p = 0; p < len; p++) begin
                if (l == rst_line && p == rst_px) begin
                    rst_n = 1'b0;
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    check($sformatf("f%0d_rst_locked", fid), locked, 0);
                    check($sformatf("f%0d_rst_errcnt", fid), err_cnt, 0);
                end
                step((p < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1);
                if (l == 0 && p == 0)
                    check($sformatf("f%0d_lock_pre", fid), locked, fid == 0 ? 0 : int'(prev_lk));
                if (l == 0 && p == 1)
                    check($sformatf("f%0d_lock_at_vs", fid), locked, exp_lk);
                if (do_cp) begin
                    for (int i = 0; i < 8; i++) begin
                        if (cps[i].line == l && cps[i].px == p) begin
                            check($sformatf("f%0d_cp%0d_active", fid, i), active, cps[i].act);
                            check($sformatf("f%0d_cp%0d_hpos", fid, i), h_pos, cps[i].h);
                            check($sformatf("f%0d_cp%0d_vpos", fid, i), v_pos, cps[i].v);
                        end
                    end
                end
            end
        end
    endtask

    int e0, f0;

    initial begin
        // After the step for (line, px) with px>=1 the outputs reflect
        // hc = px-1, vc = line.
        cps[0] = '{line: 3,  px: 6,  act: 1'b1, h: 0,  v: 0};
        cps[1] = '{line: 3,  px: 5,  act: 1'b0, h: 0,  v: 0};
        cps[2] = '{line: 2,  px: 10, act: 1'b0, h: 0,  v: 0};
        cps[3] = '{line: 10, px: 17, act: 1'b1, h: 11, v: 7};
        cps[4] = '{line: 10, px: 18, act: 1'b0, h: 0,  v: 0};
        cps[5] = '{line: 11, px: 10, act: 1'b0, h: 0,  v: 0};
        cps[6] = '{line: 7,  px: 12, act: 1'b1, h: 6,  v: 4};
        cps[7] = '{line: 5,  px: 1,  act: 1'b0, h: 0,  v: 0};

        // 1: reset
        rst_n = 1'b0; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", locked, 0);
        check("rst_active", active, 0);
        check("rst_hpos", h_pos, 0);
        check("rst_vpos", v_pos, 0);
        check("rst_err", err, 0);
        check("rst_fs", frame_start, 0);
        check("rst_errcnt", err_cnt, 0);
        rst_n = 1'b1;

        // 2: clean timing, lock at the 3rd vsync edge
        run_frame(0, -1, -1, -1, 1'b0, 1'b0);
        run_frame(1, -1, -1, -1, 1'b0, 1'b0);
        run_frame(2, -1, -1, -1, 1'b1, 1'b1);
        check("clean_no_err", err_n, 0);

        // 3: one short line while locked
        e0 = err_n; f0 = fs_n;
        run_frame(3, 5, -1, -1, 1'b1, 1'b0);
        check("short_err_pulses", err_n - e0, 1);
        check("short_lock_lag", fall_cyc - err_cyc, 1);
        check("short_locked", locked, 0);
        check("short_fs", fs_n - f0, 1);
        check("short_errcnt", err_cnt, exp_cnt(1));

        // 5: relock; every frame boundary has coincident h/v edges
        run_frame(4, -1, -1, -1, 1'b0, 1'b0);
        run_frame(5, -1, -1, -1, 1'b0, 1'b0);
        run_frame(6, -1, -1, -1, 1'b1, 1'b0);
        e0 = err_n; f0 = fs_n;
        run_frame(7, -1, -1, -1, 1'b1, 1'b1);
        check("coinc_no_err", err_n - e0, 0);
        check("coinc_fs", fs_n - f0, 1);
        check("coinc_locked", locked, 1);

        // 4: hsync lost -> hc saturates, single timeout err
        e0 = err_n;
        repeat (1100) step(1'b1, 1'b1);
        check("hlost_err_pulses", err_n - e0, 1);
        check("hlost_lock_lag", fall_cyc - err_cyc, 1);
        check("hlost_locked", locked, 0);
        check("hlost_active", active, 0);
        check("hlost_errcnt", err_cnt, exp_cnt(2));

        // 6: mid-frame reset while locked, then relock
        e0 = err_n;
        run_frame(8,  -1, -1, -1, 1'b0, 1'b0);
        run_frame(9,  -1, -1, -1, 1'b0, 1'b0);
        run_frame(10, -1, -1, -1, 1'b1, 1'b0);
        run_frame(11, -1, 5, 10, 1'b1, 1'b0);
        check("f11_end_locked", locked, 0);
        run_frame(12, -1, -1, -1, 1'b0, 1'b0);
        run_frame(13, -1, -1, -1, 1'b0, 1'b0);
        check("f13_end_locked", locked, 0);
        run_frame(14, -1, -1, -1, 1'b1, 1'b1);
        check("relock_no_err", err_n - e0, 0);

        // Error burst: 4-tick "frames"; every second edge is a violation.
        e0 = err_n;
        for (int k = 0; k < 600; k++) begin
            step(1'b0, 1'b0);
            repeat (3) step(1'b1, 1'b1);
        end
        repeat (3) step(1'b1, 1'b1);
        check("burst_err_pulses", err_n - e0, 300);
        check("burst_errcnt", err_cnt, exp_cnt(300));
        check("burst_locked", locked, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
